// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter for the single register-file write port, plus a per-register
// busy scoreboard that decode uses to stall on RAW hazards.
module rf_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_rd,
    input  logic [NREQ*XLEN-1:0] req_data,
    input  logic                 rsv_valid,
    input  logic [AW-1:0]        rsv_rd,
    input  logic [AW-1:0]        rs1,
    input  logic [AW-1:0]        rs2,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic [2**AW-1:0]     busy_mask,
    output logic                 rfwr,
    output logic [AW-1:0]        rfrd,
    output logic [XLEN-1:0]      rfD
);
    localparam int NREG = 2**AW;
    localparam int PW   = $clog2(NREQ);

    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   gnt_idx;
    logic [NREQ-1:0] gnt;
    logic            xfer;
    int              scan_idx;
    logic [AW-1:0]   xfer_rd;
    logic [XLEN-1:0] xfer_data;
    logic [NREG-1:0] busy_q, busy_d;
    logic            rfwr_q;
    logic [AW-1:0]   rfrd_q;
    logic [XLEN-1:0] rfd_q;

    // Scan from ptr upward (mod NREQ); no grants while reset is held.
    always_comb begin
        gnt      = '0;
        gnt_idx  = '0;
        xfer     = 1'b0;
        scan_idx = 0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = (int'(ptr_q) + k) % NREQ;
            if (!rst && !xfer && req_valid[scan_idx]) begin
                xfer          = 1'b1;
                gnt[scan_idx] = 1'b1;
                gnt_idx       = PW'(scan_idx);
            end
        end
    end

    assign req_ready = gnt;
    assign xfer_rd   = req_rd[gnt_idx*AW +: AW];
    assign xfer_data = req_data[gnt_idx*XLEN +: XLEN];

    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + PW'(1);
        end
    end

    // Set beats clear so a same-cycle re-reservation keeps the new owner's bit.
    assign busy_d[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < NREG; gi++) begin : g_busy
            assign busy_d[gi] = (rsv_valid && rsv_rd == AW'(gi)) ||
                                (busy_q[gi] && !(xfer && xfer_rd == AW'(gi)));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q  <= '0;
            busy_q <= '0;
            rfwr_q <= 1'b0;
            rfrd_q <= '0;
            rfd_q  <= '0;
        end else begin
            ptr_q  <= ptr_d;
            busy_q <= busy_d;
            rfwr_q <= xfer && (xfer_rd != '0);
            if (xfer) begin
                rfrd_q <= xfer_rd;
                rfd_q  <= xfer_data;
            end
        end
    end

    assign rfwr      = rfwr_q;
    assign rfrd      = rfrd_q;
    assign rfD       = rfd_q;
    assign busy_mask = busy_q;

    // The bypass term covers the write parked in the output register.
    assign rs1_busy = busy_q[rs1] || (rfwr_q && rfrd_q == rs1 && rs1 != '0);
    assign rs2_busy = busy_q[rs2] || (rfwr_q && rfrd_q == rs2 && rs2 != '0);
endmodule
